// File: rtl/gpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// gpu_isa_pkg
// Shared GPU ISA definitions: op-ID enumeration, 6-bit primary opcodes (with
// the .S bit at opcode bit 4 held at zero), R-type funct codes, instruction
// field bit positions and small word-assembly helpers. Used by the program
// loader (encode direction) and by the reverse-decoder (decode direction).
// -----------------------------------------------------------------------------
package gpu_isa_pkg;

    // Symbolic op IDs carried on the loader input; 23..31 are illegal.
    typedef enum logic [4:0] {
        OP_NOOP = 5'd0,
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_MUL  = 5'd3,
        OP_AND  = 5'd4,
        OP_OR   = 5'd5,
        OP_XOR  = 5'd6,
        OP_SHR  = 5'd7,
        OP_SHL  = 5'd8,
        OP_ADDI = 5'd9,
        OP_ANDI = 5'd10,
        OP_ORI  = 5'd11,
        OP_XORI = 5'd12,
        OP_LD   = 5'd13,
        OP_LDS  = 5'd14,
        OP_SW   = 5'd15,
        OP_SWS  = 5'd16,
        OP_BEQ  = 5'd17,
        OP_BLT  = 5'd18,
        OP_JMP  = 5'd19,
        OP_CALL = 5'd20,
        OP_RET  = 5'd21,
        OP_EXIT = 5'd22
    } op_e;

    localparam logic [4:0] OP_LAST_LEGAL = 5'd22;

    // Field bit positions inside a 32-bit instruction word.
    localparam int OPC_LSB   = 26;
    localparam int DOT_S_BIT = 30;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;

    // Primary opcodes, .S bit (opcode bit 4) shown as zero.
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_NOOP  = 6'b000001;
    localparam logic [5:0] OPC_JMP   = 6'b000010;
    localparam logic [5:0] OPC_CALL  = 6'b000011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_RET   = 6'b000110;
    localparam logic [5:0] OPC_BLT   = 6'b000111;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_EXIT  = 6'b100001;
    localparam logic [5:0] OPC_LD    = 6'b100011;
    localparam logic [5:0] OPC_LDS   = 6'b100111;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_SWS   = 6'b101111;

    // R-type funct codes.
    localparam logic [5:0] FUNCT_SHL = 6'b000000;
    localparam logic [5:0] FUNCT_SHR = 6'b000010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;

    // R-type word with shamt forced to zero.
    function automatic logic [31:0] r_type(input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd,
                                           input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    // I-type word {opcode, rs, rt, imm}.
    function automatic logic [31:0] i_type(input logic [5:0]  opc,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/instr_encode.sv
// -----------------------------------------------------------------------------
// instr_encode
// Purely combinational encoder: symbolic instruction fields -> 32-bit ISA word.
// Ports:
//   op, dot_s, rs, rt, rd, imm, jaddr : symbolic fields (EXIT warp ID on rs)
//   word                              : encoded instruction (0 when illegal)
//   illegal                           : op ID outside 0..22
// The .S flag lands on bit 30 for every op except CALL, RET and EXIT, whose
// opcodes have a fixed bit 30 of zero.
// -----------------------------------------------------------------------------
module instr_encode
    import gpu_isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic        dot_s,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    output logic [31:0] word,
    output logic        illegal
);

    logic [31:0] base_word_s;
    logic        use_dot_s;

    // Select the field layout for the op, then merge the .S flag.
    always_comb begin
        base_word_s = 32'd0;
        use_dot_s   = 1'b1;
        illegal     = 1'b0;
        case (op)
            OP_NOOP: base_word_s = {OPC_NOOP, 26'd0};
            OP_ADD:  base_word_s = r_type(rs, rt, rd, FUNCT_ADD);
            OP_SUB:  base_word_s = r_type(rs, rt, rd, FUNCT_SUB);
            OP_MUL:  base_word_s = r_type(rs, rt, rd, FUNCT_MUL);
            OP_AND:  base_word_s = r_type(rs, rt, rd, FUNCT_AND);
            OP_OR:   base_word_s = r_type(rs, rt, rd, FUNCT_OR);
            OP_XOR:  base_word_s = r_type(rs, rt, rd, FUNCT_XOR);
            OP_SHR:  base_word_s = r_type(rs, rt, rd, FUNCT_SHR);
            OP_SHL:  base_word_s = r_type(rs, rt, rd, FUNCT_SHL);
            OP_ADDI: base_word_s = i_type(OPC_ADDI, rs, rt, imm);
            OP_ANDI: base_word_s = i_type(OPC_ANDI, rs, rt, imm);
            OP_ORI:  base_word_s = i_type(OPC_ORI,  rs, rt, imm);
            OP_XORI: base_word_s = i_type(OPC_XORI, rs, rt, imm);
            OP_LD:   base_word_s = i_type(OPC_LD,   rs, rt, imm);
            OP_LDS:  base_word_s = i_type(OPC_LDS,  rs, rt, imm);
            OP_SW:   base_word_s = i_type(OPC_SW,   rs, rt, imm);
            OP_SWS:  base_word_s = i_type(OPC_SWS,  rs, rt, imm);
            OP_BEQ:  base_word_s = i_type(OPC_BEQ,  rs, rt, imm);
            OP_BLT:  base_word_s = i_type(OPC_BLT,  rs, rt, imm);
            OP_JMP:  base_word_s = {OPC_JMP, jaddr};
            OP_CALL: begin
                base_word_s = {OPC_CALL, 10'd0, imm};
                use_dot_s   = 1'b0;
            end
            OP_RET: begin
                base_word_s = {OPC_RET, 26'd0};
                use_dot_s   = 1'b0;
            end
            OP_EXIT: begin
                base_word_s = {OPC_EXIT, rs, 21'd0};
                use_dot_s   = 1'b0;
            end
            default: begin
                base_word_s = 32'd0;
                use_dot_s   = 1'b0;
                illegal     = 1'b1;
            end
        endcase
        word            = base_word_s;
        word[DOT_S_BIT] = base_word_s[DOT_S_BIT] | (use_dot_s & dot_s);
    end

endmodule

// File: rtl/instr_program_loader.sv
// -----------------------------------------------------------------------------
// instr_program_loader
// Encodes a stream of symbolic instruction beats into 32-bit ISA words, queues
// them in a DEPTH-entry FIFO and writes them to instruction memory at
// consecutive word addresses starting from BASE_ADDR.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : begin a load session (honoured only in IDLE)
//   in_valid/in_ready  : beat handshake; in_op/in_dot_s/in_rs/in_rt/in_rd/
//                        in_imm/in_jaddr carry the fields, in_last ends session
//   imem_we/imem_ready : write handshake; imem_addr/imem_wdata address & word
//   busy               : session in progress (state != IDLE)
//   done               : one-cycle pulse at session end
//   err_illegal        : sticky, an illegal op was dropped this session
//   word_count         : words written this session
// Optional build macro LOADER_TRACE_EN: prints a trace line for every write
// transfer and a warning for each illegal op.
// -----------------------------------------------------------------------------
module instr_program_loader
    import gpu_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic              in_dot_s,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_jaddr,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W:0]   word_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_r;
    logic               busy_r;
    logic               done_r;
    logic               err_illegal_r;
    logic [ADDR_W-1:0]  imem_addr_r;
    logic [ADDR_W:0]    word_count_r;

    logic [31:0]        fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic [31:0]        enc_word_s;
    logic               enc_illegal_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;

    instr_encode u_encode (
        .op      (in_op),
        .dot_s   (in_dot_s),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .jaddr   (in_jaddr),
        .word    (enc_word_s),
        .illegal (enc_illegal_s)
    );

    // Handshake decode; all terms come from registered state so in_ready does
    // not depend on a pop happening in the same cycle.
    assign fifo_full_s  = (count_r == FULL_CNT);
    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign in_ready     = (state_r == ST_LOAD) && !fifo_full_s;
    assign accept_s     = in_valid && in_ready;
    assign push_s       = accept_s && !enc_illegal_s;
    assign imem_we      = !fifo_empty_s;
    assign pop_s        = imem_we && imem_ready;

    assign imem_wdata   = fifo_mem_r[rd_ptr_r];
    assign imem_addr    = imem_addr_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_illegal  = err_illegal_r;
    assign word_count   = word_count_r;

    // FIFO storage: write the encoded word at the tail on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 32'd0;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= enc_word_s;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; push and pop together leave occupancy as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Session FSM with registered busy/done/err_illegal, write address and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_illegal_r <= 1'b0;
            imem_addr_r   <= BASE;
            word_count_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            done_r <= 1'b0;
            // Address wraps naturally at 2^ADDR_W.
            if (pop_s) begin
                imem_addr_r  <= imem_addr_r + ADDR_W'(1);
                word_count_r <= word_count_r + (ADDR_W+1)'(1);
            end else begin
                imem_addr_r  <= imem_addr_r;
                word_count_r <= word_count_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r       <= ST_LOAD;
                        busy_r        <= 1'b1;
                        err_illegal_r <= 1'b0;
                        imem_addr_r   <= BASE;
                        word_count_r  <= {(ADDR_W+1){1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (accept_s && enc_illegal_s) begin
                        err_illegal_r <= 1'b1;
                    end else begin
                        err_illegal_r <= err_illegal_r;
                    end
                    // An illegal final beat still closes the session.
                    if (accept_s && in_last) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_TRACE_EN
    logic [4:0] fifo_op_r [DEPTH];

    // Op IDs shadow the word FIFO so the trace can name each written word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_op_r[i] <= 5'd0;
            end
        end else if (push_s) begin
            fifo_op_r[wr_ptr_r] <= in_op;
        end else begin
            fifo_op_r[wr_ptr_r] <= fifo_op_r[wr_ptr_r];
        end
    end

    // Trace every write transfer and flag dropped illegal ops.
    always @(posedge clk) begin
        if (rst_n && pop_s) begin
            $display("addr=%h word=%h op=%0d",
                     imem_addr_r, imem_wdata, fifo_op_r[rd_ptr_r]);
        end
        if (rst_n && accept_s && enc_illegal_s) begin
            $display("instr_program_loader: warning: illegal op %0d dropped", in_op);
        end
    end
`else
    // Trace disabled: no file I/O.
`endif

endmodule
